audio_frame_scheduler: RTL and testbench

//  Master timing/sample scheduler for the I2S DAC serializer. From the system clock it generates
//  the BCLK and DACLRCK that clock the audio_i2s_driver. It pulls stereo sample pairs from the

---
 rtl/audio_frame_scheduler.sv | 166 ++++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_scheduler.sv
// I2S frame timing master: divides sys_clk into BCLK/DACLRCK and hands one buffered
// stereo pair to the serializer at each frame boundary, counting frames that find no pair.
//   state   | meaning
//   S_IDLE  | audio clocks stopped, BCLK/LRCK low, buffer may still be preloaded
//   S_RUN   | clocks running, words reloaded at every frame boundary
//   S_DRAIN | enable dropped, clocks run to the next boundary without reloading
module audio_frame_scheduler #(
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_BITS  = 32,
    parameter int SAMPLE_W   = 24,
    parameter int UNDER_ZERO = 0
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_smp_valid,
    input  logic [SAMPLE_W-1:0] i_smp_l,
    input  logic [SAMPLE_W-1:0] i_smp_r,
    output logic                o_smp_ready,
    output logic                oAUD_BCLK,
    output logic                oAUD_DACLRCK,
    output logic [SAMPLE_W-1:0] o_lsound_out,
    output logic [SAMPLE_W-1:0] o_rsound_out,
    output logic                o_frame_tick,
    output logic                o_underrun,
    output logic [15:0]         o_underrun_cnt,
    output logic                o_running
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                bclk_q, bclk_d;
    logic                lrck_q, lrck_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic [15:0]         ucnt_q, ucnt_d;
    logic                active, div_wrap, bclk_fall, boundary, accept, load, underrun;

    always_comb begin
        active    = (state_q != S_IDLE);
        div_wrap  = active && (div_q == DIV_LAST);
        bclk_fall = div_wrap && bclk_q;
        boundary  = bclk_fall && (bit_q == BIT_LAST);
        accept    = i_smp_valid && !full_q;
        load      = 1'b0;
        underrun  = 1'b0;
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        bclk_d    = bclk_q;
        lrck_d    = lrck_q;
        full_d    = full_q;
        buf_l_d   = buf_l_q;
        buf_r_d   = buf_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        ucnt_d    = ucnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d = S_RUN;
                    load    = full_q;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    load     = full_q;
                    underrun = !full_q;
                end
                if (!i_enable) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Re-enable before the boundary resumes with the divider untouched.
                if (i_enable)      state_d = S_RUN;
                else if (boundary) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (active) begin
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap) bclk_d = !bclk_q;
            if (bclk_fall) begin
                bit_d  = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
                lrck_d = (bit_d >= BIT_RIGHT);
            end
        end
        if (state_d == S_IDLE) begin
            div_d  = '0;
            bit_d  = '0;
            bclk_d = 1'b0;
            lrck_d = 1'b0;
        end

        if (load) begin
            out_l_d = buf_l_q;
            out_r_d = buf_r_q;
            full_d  = 1'b0;
        end
        if (underrun) begin
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            if (UNDER_ZERO != 0) begin
                out_l_d = '0;
                out_r_d = '0;
            end
        end
        // Never coincides with a load: the buffer only drains while full, and ready is low then.
        if (accept) begin
            full_d  = 1'b1;
            buf_l_d = i_smp_l;
            buf_r_d = i_smp_r;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign o_smp_ready    = !full_q;
    assign oAUD_BCLK      = bclk_q;
    assign oAUD_DACLRCK   = lrck_q;
    assign o_lsound_out   = out_l_q;
    assign o_rsound_out   = out_r_q;
    assign o_frame_tick   = boundary;
    assign o_underrun     = underrun;
    assign o_underrun_cnt = ucnt_q;
    assign o_running      = active;
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Bench for audio_frame_scheduler: a hold-last and a zero-on-underrun instance share stimulus
// and are compared against a frame-time reference model driven from elapsed running cycles.
module tb_audio_frame_scheduler;
    localparam int DIV   = 4;
    localparam int SLOT  = 32;
    localparam int W     = 24;
    localparam int FRAME = 2 * DIV * 2 * SLOT;
    localparam logic [139:0] RESET_VEC = {6'b000010, 6'b000010, 32'd0, 96'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, vld;
    logic [W-1:0] sl, sr;
    logic         rdy0, bclk0, lrck0, tick0, und0, run0;
    logic         rdy1, bclk1, lrck1, tick1, und1, run1;
    logic [W-1:0] l0, r0, l1, r1;
    logic [15:0]  cnt0, cnt1;

    audio_frame_scheduler #(.BCLK_DIV(DIV), .SLOT_BITS(SLOT), .SAMPLE_W(W), .UNDER_ZERO(0)) dut_hold (
        .sys_clk(clk), .reset(rst), .i_enable(en), .i_smp_valid(vld), .i_smp_l(sl), .i_smp_r(sr),
        .o_smp_ready(rdy0), .oAUD_BCLK(bclk0), .oAUD_DACLRCK(lrck0), .o_lsound_out(l0),
        .o_rsound_out(r0), .o_frame_tick(tick0), .o_underrun(und0), .o_underrun_cnt(cnt0),
        .o_running(run0));

    audio_frame_scheduler #(.BCLK_DIV(DIV), .SLOT_BITS(SLOT), .SAMPLE_W(W), .UNDER_ZERO(1)) dut_zero (
        .sys_clk(clk), .reset(rst), .i_enable(en), .i_smp_valid(vld), .i_smp_l(sl), .i_smp_r(sr),
        .o_smp_ready(rdy1), .oAUD_BCLK(bclk1), .oAUD_DACLRCK(lrck1), .o_lsound_out(l1),
        .o_rsound_out(r1), .o_frame_tick(tick1), .o_underrun(und1), .o_underrun_cnt(cnt1),
        .o_running(run1));

    wire [139:0] obs = {bclk0, lrck0, tick0, und0, rdy0, run0, bclk1, lrck1, tick1, und1, rdy1, run1,
                        cnt0, cnt1, l0, r0, l1, r1};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: m_t is the number of cycles spent running since the last start.
    bit           m_on = 1'b0, m_stopping = 1'b0, m_full = 1'b0;
    int           m_t = 0, m_loads = 0;
    logic [W-1:0] m_bl = '0, m_br = '0, m_wl0 = '0, m_wr0 = '0, m_wl1 = '0, m_wr1 = '0;
    logic [15:0]  m_cnt = '0;

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    function automatic logic [5:0] m_ctl();
        int   ph;
        logic b, lr, tk, un;
        ph = m_t % FRAME;
        if (!m_on) return {4'b0000, !m_full, 1'b0};
        b  = ((ph / DIV) % 2) == 1;
        lr = (ph / (2 * DIV)) >= SLOT;
        tk = (ph == FRAME - 1);
        un = tk && !m_stopping && !m_full;
        return {b, lr, tk, un, !m_full, 1'b1};
    endfunction

    function automatic logic [139:0] m_all();
        return {m_ctl(), m_ctl(), m_cnt, m_cnt, m_wl0, m_wr0, m_wl1, m_wr1};
    endfunction

    task automatic model_update(input logic e, input logic v, input logic [W-1:0] dl,
                                input logic [W-1:0] dr, input logic rs);
        bit acc, bnd, ld, un;
        if (rs) begin
            m_on = 0; m_stopping = 0; m_full = 0; m_t = 0;
            m_bl = '0; m_br = '0; m_wl0 = '0; m_wr0 = '0; m_wl1 = '0; m_wr1 = '0; m_cnt = '0;
            return;
        end
        acc = v && !m_full;
        bnd = m_on && ((m_t % FRAME) == FRAME - 1);
        ld  = 0;
        un  = 0;
        if (!m_on) begin
            if (e) begin m_on = 1; m_stopping = 0; m_t = 0; ld = m_full; end
        end else begin
            if (m_stopping && e) m_stopping = 0;
            else if (m_stopping && bnd) m_on = 0;
            else if (!m_stopping) begin
                ld = bnd && m_full;
                un = bnd && !m_full;
                if (!e) m_stopping = 1;
            end
            m_t = m_on ? m_t + 1 : 0;
        end
        if (ld) begin
            m_wl0 = m_bl; m_wr0 = m_br; m_wl1 = m_bl; m_wr1 = m_br; m_full = 0; m_loads++;
        end
        if (un) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            m_wl1 = '0; m_wr1 = '0;
        end
        if (acc) begin m_full = 1; m_bl = dl; m_br = dr; end
    endtask

    task automatic step(input logic e, input logic v, input logic [W-1:0] dl,
                        input logic [W-1:0] dr, input logic rs);
        rst = rs; en = e; vld = v; sl = dl; sr = dr;
        @(posedge clk);
        model_update(e, v, dl, dr, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 1, rnd(), rnd(), 1);
        step(1, 1, rnd(), rnd(), 1);
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_bad++; $display("FAIL reset_state got %h want %h", obs, RESET_VEC);
        end
    endtask

    task automatic test_clocking();
        int   last_tick, ticks, bad_lr;
        logic pb, pl;
        step(0, 0, rnd(), rnd(), 1);
        step(1, 0, rnd(), rnd(), 0);
        last_tick = -1; ticks = 0; bad_lr = 0; pb = bclk0; pl = lrck0;
        for (int i = 0; i < 1100; i++) begin
            step(1, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL clocking i=%0d got %h want %h", i, obs, m_all());
            end
            if (lrck0 !== pl && !(pb === 1'b1 && bclk0 === 1'b0)) bad_lr++;
            if (tick0 === 1'b1) begin
                if (last_tick >= 0) begin
                    n_cmp++;
                    if (i - last_tick !== FRAME) begin
                        n_bad++; $display("FAIL tick_period got %0d want %0d", i - last_tick, FRAME);
                    end
                end
                last_tick = i; ticks++;
            end
            pb = bclk0; pl = lrck0;
        end
        n_cmp++;
        if (ticks !== 2) begin n_bad++; $display("FAIL tick_count got %0d want 2", ticks); end
        n_cmp++;
        if (bad_lr !== 0) begin n_bad++; $display("FAIL lrck_edge got %0d off-edge changes want 0", bad_lr); end
    endtask

    task automatic test_preload();
        int unstable;
        step(0, 0, rnd(), rnd(), 1);
        step(0, 1, 24'h123456, 24'hABCDEF, 0);
        n_cmp++;
        if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL preload_ready got %b want 0", rdy0); end
        step(1, 0, rnd(), rnd(), 0);
        n_cmp++;
        if ({l0, r0, l1, r1, rdy0, und0} !== {24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL preload_words got %h %h %h %h rdy=%b und=%b want 123456 abcdef x2 rdy=1 und=0",
                              l0, r0, l1, r1, rdy0, und0);
        end
        unstable = 0;
        for (int i = 1; i < FRAME; i++) begin
            step(1, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL preload_frame i=%0d got %h want %h", i, obs, m_all());
            end
            if ({l0, r0} !== {24'h123456, 24'hABCDEF}) unstable++;
        end
        n_cmp++;
        if (unstable !== 0) begin n_bad++; $display("FAIL preload_stable got %0d changed cycles want 0", unstable); end
        n_cmp++;
        if ({tick0, und0} !== 2'b11) begin n_bad++; $display("FAIL first_tick got %b want 11", {tick0, und0}); end
    endtask

    task automatic test_underrun();
        int unders;
        unders = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL underrun i=%0d got %h want %h", i, obs, m_all());
            end
            if (und0 === 1'b1 && und1 === 1'b1) unders++;
        end
        n_cmp++;
        if ({unders, cnt0, cnt1} !== {32'd3, 16'd3, 16'd3}) begin
            n_bad++; $display("FAIL underrun_count got pulses=%0d cnt=%0d/%0d want 3 3/3", unders, cnt0, cnt1);
        end
        n_cmp++;
        if ({l0, r0, l1, r1} !== {24'h123456, 24'hABCDEF, 48'd0}) begin
            n_bad++; $display("FAIL underrun_words got %h %h %h %h want 123456 abcdef 0 0", l0, r0, l1, r1);
        end
    endtask

    task automatic test_before_tick();
        logic [W-1:0] dl, dr;
        logic [2*W-1:0] prev;
        int loads0, changes;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 2; i++) begin
            step(1, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL pretick_wait i=%0d got %h want %h", i, obs, m_all());
            end
        end
        dl = rnd(); dr = rnd();
        step(1, 1, dl, dr, 0);
        n_cmp++;
        if ({rdy0, tick0} !== 2'b01) begin n_bad++; $display("FAIL pretick_full got rdy,tick=%b want 01", {rdy0, tick0}); end
        step(1, 1, rnd(), rnd(), 0);
        n_cmp++;
        if ({l0, r0, l1, r1, rdy0} !== {dl, dr, dl, dr, 1'b1}) begin
            n_bad++; $display("FAIL pretick_load got %h %h %h %h rdy=%b want %h %h x2 rdy=1", l0, r0, l1, r1, rdy0, dl, dr);
        end
        loads0 = m_loads; changes = 0; prev = {l0, r0};
        for (int i = 0; i < 600; i++) begin
            step(1, 1, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL held_valid i=%0d got %h want %h", i, obs, m_all());
            end
            if ({l0, r0} !== prev) changes++;
            prev = {l0, r0};
        end
        n_cmp++;
        if (changes !== m_loads - loads0) begin
            n_bad++; $display("FAIL accept_vs_load got %0d loads want %0d", changes, m_loads - loads0);
        end
    endtask

    task automatic test_drain();
        int run_cnt, idle_cnt, falls;
        logic pb;
        step(0, 0, rnd(), rnd(), 1);
        step(1, 0, rnd(), rnd(), 0);
        for (int i = 0; i < FRAME && m_t != 10 * 2 * DIV; i++) step(1, 0, rnd(), rnd(), 0);
        run_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            step(0, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL drain i=%0d got %h want %h", i, obs, m_all());
            end
            if (run0 === 1'b1) run_cnt++;
        end
        n_cmp++;
        if (run_cnt !== FRAME - 1 - 80) begin n_bad++; $display("FAIL drain_len got %0d want %0d", run_cnt, FRAME - 81); end
        n_cmp++;
        if ({bclk0, lrck0, run0} !== 3'b000) begin n_bad++; $display("FAIL drain_idle got %b want 000", {bclk0, lrck0, run0}); end

        step(1, 0, rnd(), rnd(), 0);
        for (int i = 0; i < FRAME && m_t != 10 * 2 * DIV; i++) step(1, 0, rnd(), rnd(), 0);
        idle_cnt = 0; falls = 0; pb = bclk0;
        for (int i = 0; i < 620; i++) begin
            step(i >= 100, 0, rnd(), rnd(), 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL resume i=%0d got %h want %h", i, obs, m_all());
            end
            if (run0 !== 1'b1) idle_cnt++;
            if (pb === 1'b1 && bclk0 === 1'b0) falls++;
            pb = bclk0;
        end
        n_cmp++;
        if ({idle_cnt, falls} !== {32'd0, 32'd77}) begin
            n_bad++; $display("FAIL resume_gap got idle=%0d falls=%0d want idle=0 falls=77", idle_cnt, falls);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME && (m_t % FRAME) != 40 * 2 * DIV; i++) step(1, 0, rnd(), rnd(), 0);
        n_cmp++;
        if ({lrck0, run0, cnt0} !== {2'b11, 16'd1}) begin
            n_bad++; $display("FAIL mid_right_slot got lrck=%b run=%b cnt=%0d want 1 1 1", lrck0, run0, cnt0);
        end
        step(1, 1, rnd(), rnd(), 1);
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_mid got %h want %h", obs, RESET_VEC); end
    endtask

    task automatic test_random();
        logic e;
        e = 1'b1;
        step(0, 0, rnd(), rnd(), 1);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) e = !e;
            step(e, $urandom_range(0, 399) == 0, rnd(), rnd(), $urandom_range(0, 2999) == 0);
            n_cmp++;
            if (obs !== m_all()) begin
                n_bad++; $display("FAIL random i=%0d got %h want %h", i, obs, m_all());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; sl = '0; sr = '0;
        @(negedge clk);
        test_reset();
        test_clocking();
        test_preload();
        test_underrun();
        test_before_tick();
        test_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
